// File: rtl/axi3_slave_wr_ctrl.sv
// axi3_slave_wr_ctrl
//   AXI3 slave write-path controller. Accepts one write burst at a time on AW,
//   takes its W beats, writes each beat to a synchronous SRAM port, then
//   returns a single B response. FIXED, INCR and WRAP address generation;
//   reserved burst type 3 is handled as INCR.
//
// Parameters
//   DATA_W  write data width (strobe width DATA_W/8)
//   ID_W    AWID/WID/BID width
//   MEM_AW  SRAM word-address width, mem_addr = byte_addr[MEM_AW+1:2]
//
// Ports
//   ACLK, ARESET             clock, synchronous active-high reset
//   AW*  (ID,ADDR,LEN,SIZE,BURST,VALID,READY)   write address channel
//   W*   (ID,DATA,STRB,LAST,VALID,READY)        write data channel
//   B*   (ID,RESP,VALID,READY)                  write response channel
//   mem_we, mem_addr, mem_wdata, mem_wstrb      SRAM write port (registered)
//
// Configuration
//   AXI_SLV_WR_ERRCHK_EN  when defined, BRESP=SLVERR for protocol errors seen
//                         in the burst (WLAST/beat-count mismatch, WID!=AWID,
//                         reserved burst, oversize SIZE, illegal WRAP length).
//                         When undefined, BRESP is always OKAY.

module axi3_slave_wr_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned MEM_AW = 10
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_W-1:0]     AWID,
  input  logic [31:0]         AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [ID_W-1:0]     WID,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_n;
  logic                awready_q, awready_n;
  logic                wready_q, wready_n;
  logic                bvalid_q, bvalid_n;
  logic [ID_W-1:0]     bid_q, bid_n;
  logic [1:0]          bresp_q, bresp_n;
  logic                mem_we_q, mem_we_n;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_n;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_n;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_n;

  logic [ID_W-1:0]     id_q, id_n;
  logic [31:0]         addr_q, addr_n;
  logic [3:0]          len_q, len_n;
  logic [2:0]          size_q, size_n;
  logic [1:0]          burst_q, burst_n;
  logic [3:0]          beat_cnt_q, beat_cnt_n;
  logic                last_beat;

`ifdef AXI_SLV_WR_ERRCHK_EN
  localparam logic [2:0] SIZE_LIM = 3'($clog2(STRB_W));
  logic                err_q, err_n;
  logic                aw_err;
  logic                beat_err;
`else
  logic                unused_inputs;
  assign unused_inputs = ^{WLAST, WID};
`endif

  // Address of the beat after 'a'. WRAP keeps the upper bits fixed at the
  // aligned base and lets only the low len_bytes window roll over.
  function automatic logic [31:0] next_addr(input logic [31:0] a,
                                            input logic [3:0]  l,
                                            input logic [2:0]  s,
                                            input logic [1:0]  b);
    logic [31:0] step;
    logic [31:0] len_bytes;
    logic [31:0] mask;
    step      = 32'd1 << s;
    len_bytes = ({28'd0, l} + 32'd1) << s;
    mask      = len_bytes - 32'd1;
    case (b)
      2'd0:    next_addr = a;
      2'd2:    next_addr = (a & ~mask) | ((a + step) & mask);
      default: next_addr = a + step;
    endcase
  endfunction

  assign last_beat = (beat_cnt_q == len_q);

`ifdef AXI_SLV_WR_ERRCHK_EN
  assign aw_err   = (AWBURST == 2'd3) || (AWSIZE > SIZE_LIM) ||
                    ((AWBURST == 2'd2) && !(AWLEN inside {4'd1, 4'd3, 4'd7, 4'd15}));
  assign beat_err = (WLAST != last_beat) || (WID != id_q);
`endif

  always_comb begin
    state_n     = state_q;
    awready_n   = awready_q;
    wready_n    = wready_q;
    bvalid_n    = bvalid_q;
    bid_n       = bid_q;
    bresp_n     = bresp_q;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr_q;
    mem_wdata_n = mem_wdata_q;
    mem_wstrb_n = mem_wstrb_q;
    id_n        = id_q;
    addr_n      = addr_q;
    len_n       = len_q;
    size_n      = size_q;
    burst_n     = burst_q;
    beat_cnt_n  = beat_cnt_q;
`ifdef AXI_SLV_WR_ERRCHK_EN
    err_n       = err_q;
`endif

    case (state_q)
      IDLE: begin
        // AWREADY comes up one cycle after reset release.
        awready_n = 1'b1;
        if (AWVALID && awready_q) begin
          id_n       = AWID;
          addr_n     = AWADDR;
          len_n      = AWLEN;
          size_n     = AWSIZE;
          burst_n    = AWBURST;
          beat_cnt_n = '0;
`ifdef AXI_SLV_WR_ERRCHK_EN
          err_n      = aw_err;
`endif
          awready_n  = 1'b0;
          wready_n   = 1'b1;
          state_n    = DATA;
        end
      end

      DATA: begin
        if (WVALID && wready_q) begin
          mem_we_n    = 1'b1;
          mem_addr_n  = addr_q[MEM_AW+1:2];
          mem_wdata_n = WDATA;
          mem_wstrb_n = WSTRB;
          beat_cnt_n  = beat_cnt_q + 4'd1;
          addr_n      = next_addr(addr_q, len_q, size_q, burst_q);
`ifdef AXI_SLV_WR_ERRCHK_EN
          err_n       = err_q | beat_err;
`endif
          // Burst end is decided by the beat count only; WLAST is advisory.
          if (last_beat) begin
            wready_n = 1'b0;
            bvalid_n = 1'b1;
            bid_n    = id_q;
`ifdef AXI_SLV_WR_ERRCHK_EN
            bresp_n  = (err_q | beat_err) ? 2'b10 : 2'b00;
`else
            bresp_n  = 2'b00;
`endif
            state_n  = RESP;
          end
        end
      end

      RESP: begin
        if (BREADY && bvalid_q) begin
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          state_n   = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_cnt_q  <= '0;
`ifdef AXI_SLV_WR_ERRCHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_n;
      awready_q   <= awready_n;
      wready_q    <= wready_n;
      bvalid_q    <= bvalid_n;
      bid_q       <= bid_n;
      bresp_q     <= bresp_n;
      mem_we_q    <= mem_we_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
      mem_wstrb_q <= mem_wstrb_n;
      id_q        <= id_n;
      addr_q      <= addr_n;
      len_q       <= len_n;
      size_q      <= size_n;
      burst_q     <= burst_n;
      beat_cnt_q  <= beat_cnt_n;
`ifdef AXI_SLV_WR_ERRCHK_EN
      err_q       <= err_n;
`endif
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BID       = bid_q;
  assign BRESP     = bresp_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule
